branch_predictor: RTL

- Direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Sits in the fetch stage, directly upstream of the IF/ID latch.
- Each cycle it supplies predict/target/index for the fetched PC; these travel down ID/EX and EX/MEM (index, predict, br_target fields).
- Trained by the resolved-branch outcome from the EX/MEM stage; also keeps branch and mispredict statistics counters.

---
 rtl/branch_predictor.sv | 97 +++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters for the fetch stage.
// Trained from resolved branches in MEM; also counts branches and mispredicts.
module branch_predictor #(
    parameter int unsigned INDEX_W   = 3,
    parameter logic [1:0]  CTR_ALLOC = 2'b10
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [31:0]        pc,
    output logic               pred_taken,
    output logic [31:0]        pred_target,
    output logic [INDEX_W-1:0] pred_index,
    input  logic               upd_en,
    input  logic [INDEX_W-1:0] upd_index,
    input  logic [31:0]        upd_pc,
    input  logic               upd_taken,
    input  logic [31:0]        upd_target,
    input  logic               upd_predict,
    output logic               mispredict,
    output logic [31:0]        br_count,
    output logic [31:0]        mispred_count
);
    localparam int ENTRIES = 1 << INDEX_W;
    localparam int TAG_W   = 32 - INDEX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [31:0]        br_q;
    logic [31:0]        mp_q;

    logic [TAG_W-1:0] fetch_tag;
    logic [TAG_W-1:0] upd_tag;
    logic             fetch_hit;
    logic             upd_hit;
    logic [1:0]       ctr_upd;
    logic             unused_pc_bits;

    // Word-aligned PCs: the low two bits never take part in index or tag.
    assign unused_pc_bits = ^{pc[1:0], upd_pc[INDEX_W+1:0]};

    always_comb begin
        pred_index  = pc[INDEX_W+1:2];
        fetch_tag   = pc[31:INDEX_W+2];
        fetch_hit   = valid_q[pred_index] && (tag_q[pred_index] == fetch_tag);
        pred_taken  = fetch_hit && ctr_q[pred_index][1];
        pred_target = pred_taken ? target_q[pred_index] : pc + 32'd4;
    end

    always_comb begin
        upd_tag = upd_pc[31:INDEX_W+2];
        upd_hit = valid_q[upd_index] && (tag_q[upd_index] == upd_tag);
        ctr_upd = ctr_q[upd_index];
        if (upd_taken && (ctr_upd != 2'b11)) begin
            ctr_upd = ctr_upd + 2'd1;
        end else if (!upd_taken && (ctr_upd != 2'b00)) begin
            ctr_upd = ctr_upd - 2'd1;
        end
    end

    assign mispredict    = upd_en && (upd_predict != upd_taken);
    assign br_count      = br_q;
    assign mispred_count = mp_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= '0;
            br_q    <= '0;
            mp_q    <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (upd_en) begin
            if (br_q != '1) begin
                br_q <= br_q + 32'd1;
            end
            if (mispredict && (mp_q != '1)) begin
                mp_q <= mp_q + 32'd1;
            end
            if (upd_hit) begin
                ctr_q[upd_index] <= ctr_upd;
                if (upd_taken) begin
                    target_q[upd_index] <= upd_target;
                end
            end else if (upd_taken) begin
                // Taken miss replaces whatever occupied the slot.
                valid_q[upd_index]  <= 1'b1;
                tag_q[upd_index]    <= upd_tag;
                target_q[upd_index] <= upd_target;
                ctr_q[upd_index]    <= CTR_ALLOC;
            end
        end
    end
endmodule
